// File: rtl/keypad_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_matrix_scanner_if
//  Description : Key-event pop channel. The scanner presents the event at the
//                head of its FIFO, and the consumer acknowledges it with ready.
//  Signals     : valid - head entry present (scanner -> consumer)
//                code  - key code r*COLS+c of the head entry
//                rel   - head is a release event
//                ready - consumer accepts the head (consumer -> scanner)
//  Modports    : master (scanner side), slave (consumer side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_matrix_scanner_if #(
    parameter int KW = 4
);
    logic          valid;
    logic          ready;
    logic [KW-1:0] code;
    logic          rel;

    modport master (output valid, output code, output rel, input ready);
    modport slave  (input valid, input code, input rel, output ready);
endinterface
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_matrix_scanner
//  Description : ROWSxCOLS matrix-keypad scanner. It drives one row low per slot,
//                samples the active-low columns, and debounces whole frames. It then
//                serialises the key changes into binary key events and queues them
//                in a first-word-fall-through FIFO that the consumer pops with
//                valid/ready.
//  Ports       : clk       - system clock
//                RSTn      - asynchronous active-low reset
//                col       - column sense, active-low
//                row       - row drive, one-cold
//                key_state - debounced key levels, bit r*COLS+c, 1 = pressed
//                evt       - event pop channel (valid/ready/code/rel)
//                fifo_cnt  - entries held in the event FIFO
//                overflow  - sticky, an event was dropped on a full FIFO
//                clr_ovf   - clears overflow
//  Options     : KEY_RELEASE_EVT_EN - when defined, releases are also queued
//                (evt.rel=1). When undefined, only presses are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_SCANS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic                          clk,
    input  wire logic                          RSTn,
    input  wire logic [COLS-1:0]               col,
    output logic      [ROWS-1:0]               row,
    output logic      [ROWS*COLS-1:0]          key_state,
    keypad_matrix_scanner_if.master            evt,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                               overflow,
    input  wire logic                          clr_ovf
);

    localparam int NK = ROWS * COLS;
    localparam int KW = $clog2(NK);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(DEB_SCANS + 1);
`ifdef KEY_RELEASE_EVT_EN
    localparam int EW = KW + 1;
`else
    localparam int EW = KW;
`endif
    localparam logic [SW-1:0] c_deb_max = SW'(DEB_SCANS);

    // ------------------------------------------------------------------
    // Row scan timing
    // ------------------------------------------------------------------
    logic [DW-1:0] r_div;
    logic [RW-1:0] r_row_idx;
    logic          w_slot_end;
    logic          w_last_row;

    assign w_slot_end = (r_div == DW'(SCAN_DIV - 1));
    assign w_last_row = (r_row_idx == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_div     <= '0;
            r_row_idx <= '0;
        end else if (w_slot_end) begin
            r_div     <= '0;
            r_row_idx <= w_last_row ? '0 : r_row_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        row            = '1;
        row[r_row_idx] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Frame capture and debounce
    // ------------------------------------------------------------------
    logic [NK-1:0] r_raw;
    logic [NK-1:0] r_prev_raw;
    logic [SW-1:0] r_stable;
    logic          r_frame_end;
    logic [NK-1:0] w_frame;

    // The frame as it stands after this slot's sample. At the last row, this is
    // the complete frame, which the debounce compares in the same cycle.
    always_comb begin
        w_frame                           = r_raw;
        w_frame[r_row_idx*COLS +: COLS]   = ~col;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_raw       <= '0;
            r_prev_raw  <= '0;
            r_stable    <= '0;
            r_frame_end <= 1'b0;
        end else begin
            r_frame_end <= w_slot_end && w_last_row;
            if (w_slot_end) begin
                r_raw <= w_frame;
                if (w_last_row) begin
                    r_prev_raw <= w_frame;
                    if (w_frame == r_prev_raw)
                        r_stable <= (r_stable == c_deb_max) ? c_deb_max : r_stable + 1'b1;
                    else
                        r_stable <= SW'(1);
                end
            end
        end
    end

    // Commit one cycle after the frame end that made the count reach DEB_SCANS
    logic          w_commit;
    logic [NK-1:0] w_changed;

    assign w_commit = r_frame_end && (r_stable == c_deb_max) && (r_raw != key_state);
`ifdef KEY_RELEASE_EVT_EN
    assign w_changed = r_raw ^ key_state;
`else
    assign w_changed = r_raw & ~key_state;
`endif

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            key_state <= '0;
        else if (w_commit)
            key_state <= r_raw;
    end

    // ------------------------------------------------------------------
    // Event serialiser: lowest pending index first, one per cycle
    // ------------------------------------------------------------------
    logic [NK-1:0] r_pend;
    logic          r_push;
    logic [KW-1:0] r_push_code;
    logic [KW-1:0] w_low_idx;
    logic [EW-1:0] w_entry;

    always_comb begin
        w_low_idx = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (r_pend[i])
                w_low_idx = KW'(i);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_pend      <= '0;
            r_push      <= 1'b0;
            r_push_code <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_commit) begin
                r_pend <= w_changed;
            end else if (|r_pend) begin
                r_pend[w_low_idx] <= 1'b0;
                r_push            <= 1'b1;
                r_push_code       <= w_low_idx;
            end
        end
    end

`ifdef KEY_RELEASE_EVT_EN
    logic r_push_rel;

    // key_state already holds the committed level, so a 0 marks a release
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            r_push_rel <= 1'b0;
        else if (!w_commit && (|r_pend))
            r_push_rel <= ~key_state[w_low_idx];
    end

    assign w_entry = {r_push_rel, r_push_code};
`else
    assign w_entry = r_push_code;
`endif

    // ------------------------------------------------------------------
    // FWFT event FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [EW-1:0] w_head;

    assign w_full = (r_cnt == CW'(FIFO_DEPTH));
    assign w_pop  = (r_cnt != '0) && evt.ready;
    // When the FIFO is full, a simultaneous pop frees the slot that the write lands in
    assign w_wr   = r_push && (!w_full || w_pop);
    assign w_drop = r_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // A new drop wins over a clear in the same cycle
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign evt.valid = (r_cnt != '0);
    assign evt.code  = evt.valid ? w_head[KW-1:0] : '0;
`ifdef KEY_RELEASE_EVT_EN
    assign evt.rel   = evt.valid & w_head[KW];
`else
    assign evt.rel   = 1'b0;
`endif
    assign fifo_cnt  = r_cnt;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_matrix_scanner
//  Description : Bench for keypad_matrix_scanner (4x4, SCAN_DIV=20, DEB_SCANS=4,
//                FIFO_DEPTH=8). A physical keypad model drives the columns from
//                the row outputs. A frame-level reference model predicts every
//                output on every cycle, and directed scenarios pin the results
//                with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int NK       = 16;
    localparam int SCAN_DIV = 20;
    localparam int DEB      = 4;
    localparam int DEPTH    = 8;
    localparam int FRAME    = SCAN_DIV * ROWS;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_state;
    logic [3:0]  fifo_cnt;
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] keys = 16'h0;
    bit          chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    keypad_matrix_scanner_if #(.KW(4)) evt_if ();
    assign evt_if.ready = ready;

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEB_SCANS(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .RSTn(RSTn), .col(col), .row(row),
        .key_state(key_state), .evt(evt_if), .fifo_cnt(fifo_cnt),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column to its row's drive
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          k;
    logic [15:0] m_raw, m_prev, m_ks;
    int          m_stable;
    bit          m_commit_due;
    bit          m_stage_v;
    logic [4:0]  m_stage;
    logic [4:0]  ser_q[$];
    logic [4:0]  fq[$];
    bit          m_ovf;

    always @(posedge clk or negedge RSTn) begin
        bit pop, full, drop;
        int r;
        if (!RSTn) begin
            k = 0; m_raw = '0; m_prev = '0; m_ks = '0; m_stable = 0;
            m_commit_due = 0; m_stage_v = 0; m_stage = '0;
            ser_q.delete(); fq.delete(); m_ovf = 0;
        end else begin
            // FIFO side: pop and push decided on pre-edge occupancy
            pop  = (fq.size() != 0) && ready;
            full = (fq.size() == DEPTH);
            drop = m_stage_v && full && !pop;
            if (pop) void'(fq.pop_front());
            if (m_stage_v && !drop) fq.push_back(m_stage);
            if (drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            // Serialiser output register
            m_stage_v = 0;
            if (ser_q.size() != 0) begin
                m_stage   = ser_q.pop_front();
                m_stage_v = 1;
            end
            // Commit queues changed keys in ascending order
            if (m_commit_due) begin
                for (int i = 0; i < NK; i++) begin
                    if (m_raw[i] != m_ks[i]) begin
`ifdef KEY_RELEASE_EVT_EN
                        ser_q.push_back({~m_raw[i], 4'(i)});
`else
                        if (m_raw[i]) ser_q.push_back({1'b0, 4'(i)});
`endif
                    end
                end
                m_ks = m_raw;
                m_commit_due = 0;
            end
            // Scan: a row sample completes at every SCAN_DIV-th edge
            k++;
            if (k % SCAN_DIV == 0) begin
                r = ((k / SCAN_DIV) - 1) % ROWS;
                for (int c = 0; c < COLS; c++) m_raw[r*COLS+c] = keys[r*COLS+c];
                if (r == ROWS - 1) begin
                    if (m_raw == m_prev) m_stable = (m_stable >= DEB) ? DEB : m_stable + 1;
                    else m_stable = 1;
                    m_prev = m_raw;
                    if (m_stable == DEB && m_raw != m_ks) m_commit_due = 1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [3:0] e_row;
        logic [3:0] e_code;
        logic       e_rel;
        if (RSTn && chk_en) begin
            e_row  = ~(4'b0001 << ((k / SCAN_DIV) % ROWS));
            e_code = (fq.size() != 0) ? fq[0][3:0] : 4'h0;
            e_rel  = (fq.size() != 0) ? fq[0][4] : 1'b0;
            check("cycle", {1'b0, row, key_state, evt_if.valid, evt_if.code, evt_if.rel, fifo_cnt, overflow},
                  {1'b0, e_row, m_ks, fq.size() != 0, e_code, e_rel, 4'(fq.size()), m_ovf});
        end
    end

    // Log of events actually popped from the DUT
    logic [4:0] log_q[$];
    always @(posedge clk)
        if (RSTn && evt_if.valid && evt_if.ready) log_q.push_back({evt_if.rel, evt_if.code});

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset mid-scan
        wait_cyc(3);
        RSTn = 1'b1;
        wait_cyc(37);
        #2 RSTn = 1'b0;
        #1;
        check("rst_row", {28'h0, row}, 32'h0000_000E);
        check("rst_valid", {31'h0, evt_if.valid}, 32'h0);
        check("rst_keys", {16'h0, key_state}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_cnt", {28'h0, fifo_cnt}, 32'h0);
        @(negedge clk);
        RSTn = 1'b1;
        chk_en = 1'b1;

        // Hold r2c1 (code 9)
        keys[9] = 1'b1;
        wait_cyc(8 * FRAME);
        check("hold9_keys", {16'h0, key_state}, 32'h0000_0200);
        check("hold9_model", {16'h0, m_ks}, 32'h0000_0200);
        check("hold9_nevt", log_q.size(), 1);
        if (log_q.size() >= 1) check("hold9_evt", {27'h0, log_q[0]}, 32'h09);
        log_q.delete();

        // Release key 9
        keys[9] = 1'b0;
        wait_cyc(8 * FRAME);
        check("rel9_keys", {16'h0, key_state}, 32'h0);
`ifdef KEY_RELEASE_EVT_EN
        check("rel9_nevt", log_q.size(), 1);
        if (log_q.size() >= 1) check("rel9_evt", {27'h0, log_q[0]}, 32'h19);
`else
        check("rel9_nevt", log_q.size(), 0);
`endif
        log_q.delete();

        // Bounce r0c3 for three frames, then hold
        keys[3] = 1'b1; wait_cyc(FRAME);
        keys[3] = 1'b0; wait_cyc(FRAME);
        keys[3] = 1'b1; wait_cyc(FRAME);
        check("bounce_nevt", log_q.size(), 0);
        check("bounce_keys", {16'h0, key_state}, 32'h0);
        wait_cyc(8 * FRAME);
        check("hold3_keys", {16'h0, key_state}, 32'h0000_0008);
        check("hold3_nevt", log_q.size(), 1);
        if (log_q.size() >= 1) check("hold3_evt", {27'h0, log_q[0]}, 32'h03);
        keys = 16'h0;
        wait_cyc(8 * FRAME);
        log_q.delete();

        // Keys 3 and 12 in the same frame, consumer stalled
        ready = 1'b0;
        keys[3] = 1'b1; keys[12] = 1'b1;
        wait_cyc(8 * FRAME);
        check("two_cnt", {28'h0, fifo_cnt}, 32'd2);
        check("two_head", {28'h0, evt_if.code}, 32'd3);
        check("two_keys", {16'h0, key_state}, 32'h0000_1008);
        ready = 1'b1;
        wait_cyc(4);
        check("two_nevt", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("two_evt0", {27'h0, log_q[0]}, 32'h03);
            check("two_evt1", {27'h0, log_q[1]}, 32'h0C);
        end
        keys = 16'h0;
        wait_cyc(8 * FRAME);
        log_q.delete();

        // Nine presses into a stalled 8-deep FIFO
        ready = 1'b0;
        keys = 16'h01FF;
        wait_cyc(8 * FRAME);
        check("ovf_cnt", {28'h0, fifo_cnt}, 32'd8);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        check("ovf_head", {28'h0, evt_if.code}, 32'd0);
        clr_ovf = 1'b1;
        wait_cyc(1);
        clr_ovf = 1'b0;
        check("ovf_clr", {31'h0, overflow}, 32'd0);
        ready = 1'b1;
        wait_cyc(12);
        check("ovf_nevt", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_q.size()) check("ovf_evt", {27'h0, log_q[i]}, 32'(i));
        keys = 16'h0;
        wait_cyc(8 * FRAME);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
